// File: rtl/rv_imm_gen_pipe_pkg.sv
// Shared type codes and parameter checks for the rv_imm_gen_pipe immediate generator.
// Defining RV_IMM_RVC_EN widens the type code to 4 bits and enables the compressed formats.
package rv_imm_pkg;

  typedef logic [3:0] imm_code_t;

  localparam imm_code_t IMM_I     = 4'd0;
  localparam imm_code_t IMM_I_LD  = 4'd1;
  localparam imm_code_t IMM_S     = 4'd2;
  localparam imm_code_t IMM_B     = 4'd3;
  localparam imm_code_t IMM_U     = 4'd4;
  localparam imm_code_t IMM_J     = 4'd5;
  localparam imm_code_t IMM_CSR   = 4'd6;
  localparam imm_code_t IMM_SHAMT = 4'd7;
  localparam imm_code_t IMM_CI    = 4'd8;
  localparam imm_code_t IMM_CIW   = 4'd9;
  localparam imm_code_t IMM_CLS   = 4'd10;
  localparam imm_code_t IMM_CJ    = 4'd11;
  localparam imm_code_t IMM_CB    = 4'd12;

`ifdef RV_IMM_RVC_EN
  localparam int IMM_TYPE_W_DEF = 4;
`else
  localparam int IMM_TYPE_W_DEF = 3;
`endif

  function automatic bit xlen_legal(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit type_width_legal(int w);
`ifdef RV_IMM_RVC_EN
    return (w == 4);
`else
    return (w == 3);
`endif
  endfunction

endpackage

// File: rtl/rv_imm_gen_pipe_if.sv
// Handshake bundle between producer, rv_imm_gen_pipe and its consumer.
interface rv_imm_gen_pipe_if
  import rv_imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int IMM_TYPE_WIDTH = IMM_TYPE_W_DEF,
  parameter int TAG_WIDTH      = 8
);

  logic                      in_valid_in;
  logic                      in_ready_out;
  logic [INSTR_WIDTH-1:0]    instr_in;
  logic [IMM_TYPE_WIDTH-1:0] imm_type_in;
  logic [TAG_WIDTH-1:0]      tag_in;
  logic                      out_valid_out;
  logic                      out_ready_in;
  logic [XLEN-1:0]           imm_out;
  logic [TAG_WIDTH-1:0]      tag_out;
  logic                      type_err_out;

  modport master (
    output in_valid_in, instr_in, imm_type_in, tag_in, out_ready_in,
    input  in_ready_out, out_valid_out, imm_out, tag_out, type_err_out
  );

  modport slave (
    input  in_valid_in, instr_in, imm_type_in, tag_in, out_ready_in,
    output in_ready_out, out_valid_out, imm_out, tag_out, type_err_out
  );

endinterface

// File: rtl/rv_imm_gen_pipe_decode.sv
// Combinational immediate format mux; RVC formats exist only when RV_IMM_RVC_EN is defined.
module rv_imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int IMM_TYPE_WIDTH = IMM_TYPE_W_DEF
) (
  input  logic [INSTR_WIDTH-1:0]    instr_i,
  input  logic [IMM_TYPE_WIDTH-1:0] imm_type_i,
  output logic [XLEN-1:0]           imm_o,
  output logic                      type_err_o
);

  logic [31:0] w_s;
  logic [31:0] raw_s;
  logic        sext_s;
  logic        err_s;
  imm_code_t   code_s;
  logic        unused_instr_s;

  assign w_s            = instr_i[31:0];
  assign code_s         = imm_code_t'(imm_type_i);
  assign unused_instr_s = ^instr_i;

  // raw_s is built 32 bits wide; sext_s says whether bit 31 replicates up to XLEN
  always_comb begin
    raw_s  = {{20{w_s[31]}}, w_s[31:20]};
    sext_s = 1'b1;
    err_s  = 1'b0;
    case (code_s)
      IMM_I, IMM_I_LD: raw_s = {{20{w_s[31]}}, w_s[31:20]};
      IMM_S:     raw_s = {{20{w_s[31]}}, w_s[31:25], w_s[11:7]};
      IMM_B:     raw_s = {{19{w_s[31]}}, w_s[31], w_s[7], w_s[30:25], w_s[11:8], 1'b0};
      IMM_U:     raw_s = {w_s[31:12], 12'h000};
      IMM_J:     raw_s = {{11{w_s[31]}}, w_s[31], w_s[19:12], w_s[20], w_s[30:21], 1'b0};
      IMM_CSR: begin
        raw_s  = {27'h0, w_s[19:15]};
        sext_s = 1'b0;
      end
      IMM_SHAMT: begin
        raw_s  = (XLEN == 64) ? {26'h0, w_s[25:20]} : {27'h0, w_s[24:20]};
        sext_s = 1'b0;
      end
`ifdef RV_IMM_RVC_EN
      IMM_CI:    raw_s = {{26{w_s[12]}}, w_s[12], w_s[6:2]};
      IMM_CIW: begin
        raw_s  = {22'h0, w_s[10:7], w_s[12:11], w_s[5], w_s[6], 2'b00};
        sext_s = 1'b0;
      end
      IMM_CLS: begin
        raw_s  = {25'h0, w_s[5], w_s[12:10], w_s[6], 2'b00};
        sext_s = 1'b0;
      end
      IMM_CJ:    raw_s = {{20{w_s[12]}}, w_s[12], w_s[8], w_s[10:9], w_s[6], w_s[7],
                          w_s[2], w_s[11], w_s[5:3], 1'b0};
      IMM_CB:    raw_s = {{23{w_s[12]}}, w_s[12], w_s[6:5], w_s[2], w_s[11:10],
                          w_s[4:3], 1'b0};
`endif
      default:   err_s = 1'b1;
    endcase
  end

  assign imm_o      = sext_s ? XLEN'($signed(raw_s)) : XLEN'(raw_s);
  assign type_err_o = err_s;

endmodule

// File: rtl/rv_imm_gen_pipe.sv
// Pipelined immediate generator: decode into a registered output slot backed by one skid slot.
// RV_IMM_RVC_EN (optional) adds compressed-immediate formats with a 4-bit type code.
module rv_imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int IMM_TYPE_WIDTH = IMM_TYPE_W_DEF,
  parameter int TAG_WIDTH      = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  rv_imm_gen_pipe_if.slave bus
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("rv_imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!type_width_legal(IMM_TYPE_WIDTH)) begin : g_bad_tw
    $error("rv_imm_gen_pipe: IMM_TYPE_WIDTH does not match RV_IMM_RVC_EN setting");
  end

  logic [XLEN-1:0]      dec_imm_s;
  logic                 dec_err_s;
  logic                 in_ready_s;
  logic                 in_fire_s;
  logic                 out_fire_s;

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      out_imm_q,   out_imm_d;
  logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
  logic                 out_err_q,   out_err_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]      skid_imm_q,   skid_imm_d;
  logic [TAG_WIDTH-1:0] skid_tag_q,   skid_tag_d;
  logic                 skid_err_q,   skid_err_d;

  rv_imm_decode #(
    .XLEN           (XLEN),
    .INSTR_WIDTH    (INSTR_WIDTH),
    .IMM_TYPE_WIDTH (IMM_TYPE_WIDTH)
  ) u_decode (
    .instr_i    (bus.instr_in),
    .imm_type_i (bus.imm_type_in),
    .imm_o      (dec_imm_s),
    .type_err_o (dec_err_s)
  );

  // Ready depends only on skid occupancy, so out_ready_in never reaches in_ready_out.
  assign in_ready_s = ~skid_valid_q;
  assign in_fire_s  = bus.in_valid_in & in_ready_s;
  assign out_fire_s = out_valid_q & bus.out_ready_in;

  // Slot steering: the skid drains first so ordering stays FIFO
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush_in) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm_s;
        out_tag_d   = bus.tag_in;
        out_err_d   = dec_err_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm_s;
      skid_tag_d   = bus.tag_in;
      skid_err_d   = dec_err_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Slot registers, all cleared by the asynchronous reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign bus.in_ready_out  = in_ready_s;
  assign bus.out_valid_out = out_valid_q;
  assign bus.imm_out       = out_imm_q;
  assign bus.tag_out       = out_tag_q;
  assign bus.type_err_out  = out_err_q;

endmodule

// File: doc/rv_imm_gen_pipe.md
Name: rv_imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts instructions with an immediate-type code over a valid/ready handshake and returns the sign- or zero-extended XLEN-wide immediate one cycle later. A 2-entry skid buffer lets the block sit between fetch and the register-read stage without combinational ready paths. It supports XLEN 32/64, adds a shift-amount format and a flush, and passes a tag through unchanged.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64
INSTR_WIDTH, 32, instruction input width
IMM_TYPE_WIDTH, 3, width of type code (4 when RV_IMM_RVC_EN is defined)
TAG_WIDTH, 8, sideband tag width (e.g. ROB index or PC low bits)

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  asynchronous active-low reset
flush_in  in  1  synchronous pipeline flush
in_valid_in  in  1  upstream item valid
in_ready_out  out  1  block can accept an item
instr_in  in  INSTR_WIDTH  instruction word
imm_type_in  in  IMM_TYPE_WIDTH  immediate format select
tag_in  in  TAG_WIDTH  sideband tag
out_valid_out  out  1  immediate valid
out_ready_in  in  1  downstream accepts
imm_out  out  XLEN  generated immediate
tag_out  out  TAG_WIDTH  tag of the item in imm_out
type_err_out  out  1  reserved type code was used for this item

Behaviour:
- Type codes (sign-extend from instr[31] to XLEN unless stated otherwise):
  - 0 = I (ALU)
  - 1 = I (load/JALR)
  - 2 = S {31:25,11:7}
  - 3 = B {31,7,30:25,11:8,0}
  - 4 = U {31:12,12'h0}, sign-extended above bit 31 when XLEN=64
  - 5 = J {31,19:12,20,30:21,0}
  - 6 = CSR zimm: zero-extended instr[19:15]
  - 7 = SHAMT: zero-extended instr[25:20] for XLEN=64, instr[24:20] for XLEN=32
- Codes outside the defined set produce I-format and set type_err_out for that item.
- Decode is combinational from the input. The result is registered into an output slot.
- Storage: output slot (out_valid_out, imm_out, tag_out, type_err_out) plus one skid slot.
- in_ready_out = !skid_valid. It is a registered-state function only, with no combinational path from out_ready_in.
- Input handshake fires when in_valid_in && in_ready_out. Output handshake fires when out_valid_out && out_ready_in.
- Latency: 1 cycle from accepted input to out_valid_out when the output slot is free. Throughput is 1 item/cycle while out_ready_in stays high.
- Accept with output slot empty, or output firing in the same cycle: the item goes to the output slot.
- Accept while the output slot is held (not firing): the item goes to the skid slot and in_ready_out drops next cycle.
- Output fires while skid is full: skid moves to the output slot and in_ready_out rises next cycle.
- Ordering is strictly FIFO. No item is dropped or duplicated.
- flush_in high at a clock edge clears both slots' valid bits. Any input handshaking in that same cycle is discarded. in_ready_out=1 the next cycle.
- Data registers need not be cleared on flush.
- Reset (async assert, any time including mid-transfer): out_valid_out=0, skid empty, in_ready_out=1, imm_out=0, tag_out=0, type_err_out=0.
- imm_out, tag_out and type_err_out are stable while out_valid_out && !out_ready_in.

Optional Feature:
- Macro: RV_IMM_RVC_EN.
- When defined, IMM_TYPE_WIDTH must be 4. Codes 8-12 decode RVC immediates from instr[15:0]:
  - 8 = CI (c.addi), sign-extended 6-bit
  - 9 = CIW (c.addi4spn), zero-extended nzuimm
  - 10 = CL/CS word offset, zero-extended
  - 11 = CJ, sign-extended 12-bit
  - 12 = CB branch, sign-extended 9-bit
- Codes 13-15 set type_err_out.
- When not defined, codes at or above 8 cannot occur and no RVC logic is synthesised.

Decomposition:
- rv_imm_pkg: type-code localparams (IMM_I, IMM_I_LD, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR, IMM_SHAMT, IMM_C*), plus the XLEN legality check.
- Sub-module rv_imm_decode: the purely combinational format mux, instantiated once ahead of the skid/output registers.

Test Plan:
1. XLEN=32, type 0, instr 0xFFF00093 -> imm_out 0xFFFFFFFF one cycle after accept. Type 2, 0xFE20AE23 -> 0xFFFFFFFC. Type 3, 0xFE000FE3 -> 0xFFFFFFFE.
2. Type 4, 0x123450B7 -> 0x12345000. XLEN=64, type 4, 0x800000B7 -> 0xFFFFFFFF80000000. XLEN=64, type 7, 0x03F0D093 -> 0x3F.
3. Backpressure: stream tags 1..6 back-to-back with out_ready_in low for 3 cycles mid-stream -> in_ready_out low exactly while skid is full; tags out in order 1..6; none lost; outputs stable while stalled.
4. Flush with both slots full and in_valid_in high -> next cycle out_valid_out=0, in_ready_out=1; the flushed-cycle input never appears.
5. Assert rst_n_in low between clock edges while out_valid_out=1 -> out_valid_out=0 and imm_out=0 immediately; first post-reset input has 1-cycle latency.
6. RV_IMM_RVC_EN: type 8, instr 0x1FFD (c.addi x31,-1) -> all-ones; type 13 -> type_err_out=1.
